// File: rtl/fwd_mux_pipe.sv
// fwd_mux_pipe: selects one of NUM_IN data sources on each upstream transfer
// and buffers the selected value in a two-entry (main + skid) output stage,
// so that in_ready depends only on registered state.
//
// Ports:
//   clk        clock, rising-edge
//   rst        synchronous active-high reset
//   flush      discards all buffered entries (drops any input offered with it)
//   in_valid   upstream transfer present
//   in_ready   block can accept an upstream transfer (state != TWO)
//   sel        source index, sampled with in_valid
//   in_data    flattened sources, source k at [k*WIDTH +: WIDTH]
//   out_valid  out_data holds a valid entry (state != EMPTY)
//   out_ready  downstream accepts the entry
//   out_data   selected value, always driven from the main entry
//   sel_err    one-cycle pulse after an accepted out-of-range select
//   err_count  saturating count of accepted out-of-range selects
//
// States:
//   state | meaning
//   EMPTY | no entry buffered
//   ONE   | main holds the head entry
//   TWO   | main holds the head entry, skid holds the next one

module fwd_mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    sel_err,
  output logic [7:0]              err_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  // One extra bit so NUM_IN = 2**SEL_W is representable.
  localparam logic [SEL_W:0] SEL_LIMIT = NUM_IN[SEL_W:0];

  logic [1:0]       state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] picked;
  logic             in_range;
  logic             accept;
  logic             fire;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign in_range  = ({1'b0, sel} < SEL_LIMIT);

  // Out-of-range selects fall through to source 0 and are still delivered.
  always_comb begin
    picked = in_data[WIDTH-1:0];
    for (int k = 1; k < NUM_IN; k++) begin
      if ({1'b0, sel} == k[SEL_W:0]) begin
        picked = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      sel_err   <= 1'b0;
      err_count <= 8'd0;
    end else if (flush) begin
      // Input offered with flush is dropped, including its error accounting.
      state   <= EMPTY;
      sel_err <= 1'b0;
    end else begin
      sel_err <= accept && !in_range;
      if (accept && !in_range && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q <= picked;
            state  <= ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_q <= picked;
          end else if (accept) begin
            skid_q <= picked;
            state  <= TWO;
          end else if (fire) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/fwd_mux_pipe.md
FWD_MUX_PIPE -- requirements
Module: fwd_mux_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the bit width of each data source and of the output.
REQ-002 The block SHALL have parameter NUM_IN, default 3, legal range 2..16, meaning the number of data sources.
REQ-003 The block SHALL have parameter SEL_W, default 2, meaning the select width; SEL_W SHALL satisfy 2**SEL_W >= NUM_IN.
REQ-004 The block SHALL have a single clock `clk`; reset `rst` is synchronous and active-high.
REQ-005 Port list, in this order, SHALL be:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  discards all buffered entries.
- in_valid  in  1  the upstream transfer is present.
- in_ready  out  1  the block can accept an upstream transfer.
- sel  in  SEL_W  source index, sampled with in_valid.
- in_data  in  NUM_IN*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data holds a valid entry.
- out_ready  in  1  the downstream side accepts the entry.
- out_data  out  WIDTH  the selected value.
- sel_err  out  1  one-cycle pulse signalling an out-of-range select.
- err_count  out  8  saturating count of out-of-range selects.

Function
REQ-006 An accept SHALL occur when in_valid && in_ready; a fire SHALL occur when out_valid && out_ready.
REQ-007 On accept, the block SHALL capture in_data[sel] when sel < NUM_IN, else in_data[0], into the buffer entry.
REQ-008 The buffer SHALL have two entries, main and skid, tracked by a state machine with states EMPTY, ONE and TWO.
REQ-009 In EMPTY, an accept SHALL load main and move to ONE; otherwise the state SHALL stay EMPTY.
REQ-010 In ONE, transitions SHALL be:
- accept with fire: load main with the new value, stay ONE.
- accept without fire: load skid, go to TWO.
- fire without accept: go to EMPTY.
- neither: hold.
REQ-011 In TWO, transitions SHALL be:
- fire: copy skid to main, go to ONE.
- no fire: hold.
REQ-012 in_ready SHALL be 1 exactly when the state is not TWO, and SHALL depend only on registered state, never combinationally on out_ready.
REQ-013 out_valid SHALL be 1 exactly when the state is not EMPTY, and out_data SHALL always be driven from main.
REQ-014 Latency from accept in EMPTY to out_valid SHALL be 1 cycle.
REQ-015 Full throughput of one transfer per cycle SHALL be sustained while out_ready=1.
REQ-016 While out_valid && !out_ready, out_data and out_valid SHALL remain stable.
REQ-017 Entries SHALL leave in accept order; no entry may be lost or duplicated.
REQ-018 flush SHALL take priority over accept and fire:
- on the next edge the state SHALL be EMPTY.
- an input offered in the flush cycle SHALL be dropped.
- the dropped input SHALL not affect sel_err or err_count.
REQ-019 sel_err SHALL pulse high for exactly one cycle, in the cycle after an accept with sel >= NUM_IN, and SHALL be 0 otherwise.
REQ-020 err_count SHALL increment by 1 per accepted out-of-range select and SHALL saturate at 255 without wrapping.
REQ-021 err_count SHALL ignore out-of-range selects that are not accepted.
REQ-022 When NUM_IN = 2**SEL_W, sel_err SHALL never assert.
REQ-023 The default out-of-range behaviour SHALL be that the value is still delivered (in_data[0]); it SHALL NOT be dropped.

Reset
REQ-024 While rst=1 at an edge, the following SHALL be set, regardless of other inputs:
- state to EMPTY, so out_valid=0 and in_ready=1.
- out_data to 0.
- sel_err to 0.
- err_count to 0.
REQ-025 rst SHALL take priority over flush.
REQ-026 Reset asserted mid-operation SHALL discard both entries.
REQ-027 Any transfer offered in a reset cycle SHALL be ignored.

Verification
REQ-028 Single transfer: WIDTH=32, in_data={C,B,A}={3,2,1}, sel=2, out_ready=1 -> the next cycle shows out_valid=1 and out_data=3, then out_valid returns to 0.
REQ-029 Back-pressure: 3 accepts (sel=0,1,2; sources 10,20,30) with out_ready=0 -> in_ready drops to 0 after 2 accepts and out_data holds 10. Releasing out_ready then gives the stream 10, 20, 30 in order.
REQ-030 Out-of-range select: NUM_IN=3, sel=3, in_data[0]=0xAA -> out_data=0xAA, sel_err pulses 1 cycle, err_count=1. After 300 such accepts, err_count=255.
REQ-031 Flush: state TWO with in_valid=1 during flush -> the next cycle shows out_valid=0 and in_ready=1, and no stale data appears afterwards.
REQ-032 Streaming: 100 random transfers with random out_ready -> the scoreboard matches the expected stream exactly, and when out_ready is held at 1, throughput is 1 per cycle.
REQ-033 Reset mid-stream: rst asserted in state TWO with err_count=5 -> the next cycle shows out_valid=0, in_ready=1, out_data=0 and err_count=0.
